// File: rtl/imem_fetch_stage.sv
// ---------------------------------------------------------------------------
// imem_fetch_stage
//
// Word-indexed instruction memory fused with the IF/ID pipeline register.
// The fetch address PCF is decoded into a word index. The addressed word is
// captured into the D-stage register on the next rising edge. StallF holds
// the D-stage register and FlushD inserts a bubble. A fetch that is
// misaligned or beyond the array is turned into a faulting bubble. It is
// recorded in a sticky flag that only reset clears.
// The array is loaded through a dedicated program port. A fetch of the word
// being written in the same cycle sees the new data.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous, active-low reset (D-stage register and flag)
//   PCF           fetch byte address from the PC register
//   StallF        hold the D-stage outputs for this edge
//   FlushD        load a bubble into the D stage (wins over StallF)
//   prog_we       program-load write enable
//   prog_addr     program-load word index
//   prog_data     program-load instruction word
//   InstrD        instruction presented to the decoder
//   PCD           byte address of InstrD
//   ValidD        InstrD is a real fetched instruction
//   FaultD        the fetch now in D was misaligned or out of range
//   fault_sticky  a fetch fault has been loaded since reset
// ---------------------------------------------------------------------------
module imem_fetch_stage #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013,
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       PCF,
    input  logic              StallF,
    input  logic              FlushD,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] InstrD,
    output logic [31:0]       PCD,
    output logic              ValidD,
    output logic              FaultD,
    output logic              fault_sticky
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     rd_index;
    logic              misaligned;
    logic              out_of_range;
    logic              fault;
    logic [DATA_W-1:0] rd_word;
    logic              load_fetch;

    logic [DATA_W-1:0] instr_p1;
    logic [31:0]       pc_p1;
    logic              vld_p1;
    logic              fault_p1;
    logic              sticky_p1;

    // ---- F stage: address decode, fault detection, array read ----
    always_comb begin
        rd_index     = PCF[AW+1:2];
        misaligned   = (PCF[1:0] != 2'b00);
        // Address bits above the array make the fetch fault. Fetches do not
        // wrap around to index 0.
        out_of_range = (PCF[31:AW+2] != '0);
        fault        = misaligned | out_of_range;
        // Write-first forwarding for a fetch of the word being loaded.
        if (prog_we && (prog_addr == rd_index)) begin
            rd_word = prog_data;
        end else begin
            rd_word = mem[rd_index];
        end
        load_fetch = !FlushD && !StallF;
    end

    // Program-load port: independent of stall/flush, contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // ---- F -> D boundary: IF/ID register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1  <= NOP_INSTR;
            pc_p1     <= '0;
            vld_p1    <= 1'b0;
            fault_p1  <= 1'b0;
            sticky_p1 <= 1'b0;
        end else begin
            if (FlushD) begin
                instr_p1 <= NOP_INSTR;
                pc_p1    <= '0;
                vld_p1   <= 1'b0;
                fault_p1 <= 1'b0;
            end else if (!StallF) begin
                pc_p1 <= PCF;
                if (fault) begin
                    instr_p1 <= NOP_INSTR;
                    vld_p1   <= 1'b0;
                    fault_p1 <= 1'b1;
                end else begin
                    instr_p1 <= rd_word;
                    vld_p1   <= 1'b1;
                    fault_p1 <= 1'b0;
                end
            end
            // Only a faulting fetch that actually loads into D is recorded.
            if (load_fetch && fault) begin
                sticky_p1 <= 1'b1;
            end
        end
    end

    assign InstrD       = instr_p1;
    assign PCD          = pc_p1;
    assign ValidD       = vld_p1;
    assign FaultD       = fault_p1;
    assign fault_sticky = sticky_p1;

endmodule

// File: tb/tb_imem_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_stage
//
// Directed bench for imem_fetch_stage. Each drive step pushes the output
// state that is expected after the coming edge. The expected values are
// worked out by hand. A monitor pops one entry per edge and compares it.
// Asynchronous reset checks are made directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_imem_fetch_stage;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       PCF = '0;
    logic              StallF = 1'b0;
    logic              FlushD = 1'b0;
    logic              prog_we = 1'b0;
    logic [AW-1:0]     prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;
    logic [DATA_W-1:0] InstrD;
    logic [31:0]       PCD;
    logic              ValidD;
    logic              FaultD;
    logic              fault_sticky;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        fault;
        logic        sticky;
    } exp_t;

    exp_t sb[$];

    imem_fetch_stage #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .StallF      (StallF),
        .FlushD      (FlushD),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .ValidD      (ValidD),
        .FaultD      (FaultD),
        .fault_sticky(fault_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk(e.name, "InstrD", InstrD, e.instr);
        chk(e.name, "PCD", PCD, e.pc);
        chk(e.name, "ValidD", {31'b0, ValidD}, {31'b0, e.valid});
        chk(e.name, "FaultD", {31'b0, FaultD}, {31'b0, e.fault});
        chk(e.name, "fault_sticky", {31'b0, fault_sticky}, {31'b0, e.sticky});
    endtask

    // Monitor: one expected state per edge, sampled 1 time unit after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            chk_all(sb.pop_front());
        end
    end

    // Drive one edge worth of inputs and queue the post-edge expectation.
    task automatic step(input string name, input logic [31:0] pcf,
                        input logic stall, input logic flush,
                        input logic we, input logic [AW-1:0] addr,
                        input logic [31:0] data,
                        input logic [31:0] e_instr, input logic [31:0] e_pc,
                        input logic e_v, input logic e_f, input logic e_s);
        exp_t e;
        PCF       = pcf;
        StallF    = stall;
        FlushD    = flush;
        prog_we   = we;
        prog_addr = addr;
        prog_data = data;
        e.name = name; e.instr = e_instr; e.pc = e_pc;
        e.valid = e_v; e.fault = e_f; e.sticky = e_s;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [AW-1:0] addr, input logic [31:0] data);
        // Flushed during loading so D holds a bubble.
        step("load", 32'h0, 1'b0, 1'b1, 1'b1, addr, data, NOP, 32'h0, 0, 0, 0);
    endtask

    initial begin
        exp_t r;
        int   waited;
        r.name = "reset"; r.instr = NOP; r.pc = 32'h0;
        r.valid = 0; r.fault = 0; r.sticky = 0;

        repeat (2) @(posedge clk);
        #2;
        chk_all(r);
        rst_n = 1'b1;

        load(8'd0,   32'h0011_0113);
        load(8'd1,   32'h0010_8093);
        load(8'd2,   32'h0020_8113);
        load(8'd3,   32'h0031_8193);
        load(8'd255, 32'h0FF0_0093);

        // basic fetch, one-cycle latency
        step("fetch0", 32'h0, 0, 0, 0, 8'd0, 32'h0, 32'h0011_0113, 32'h0, 1, 0, 0);
        step("fetch4", 32'h4, 0, 0, 0, 8'd0, 32'h0, 32'h0010_8093, 32'h4, 1, 0, 0);
        // stall for three edges while PCF moves on
        step("stall8",  32'h8, 1, 0, 0, 8'd0, 32'h0, 32'h0010_8093, 32'h4, 1, 0, 0);
        step("stall12", 32'hC, 1, 0, 0, 8'd0, 32'h0, 32'h0010_8093, 32'h4, 1, 0, 0);
        step("stall12b",32'hC, 1, 0, 0, 8'd0, 32'h0, 32'h0010_8093, 32'h4, 1, 0, 0);
        step("release12", 32'hC, 0, 0, 0, 8'd0, 32'h0, 32'h0031_8193, 32'hC, 1, 0, 0);
        // flush beats stall
        step("flush_stall", 32'h8, 1, 1, 0, 8'd0, 32'h0, NOP, 32'h0, 0, 0, 0);
        // a stalled or flushed faulting address does not set the sticky flag
        step("stall_fault", 32'h6, 1, 0, 0, 8'd0, 32'h0, NOP, 32'h0, 0, 0, 0);
        step("flush_fault", 32'h6, 0, 1, 0, 8'd0, 32'h0, NOP, 32'h0, 0, 0, 0);
        // faults
        step("misaligned", 32'h6,   0, 0, 0, 8'd0, 32'h0, NOP, 32'h6,   0, 1, 1);
        step("range400",   32'h400, 0, 0, 0, 8'd0, 32'h0, NOP, 32'h400, 0, 1, 1);
        step("last_word",  32'h3FC, 0, 0, 0, 8'd0, 32'h0, 32'h0FF0_0093, 32'h3FC, 1, 0, 1);
        step("msb_set", 32'h8000_0000, 0, 0, 0, 8'd0, 32'h0, NOP, 32'h8000_0000, 0, 1, 1);
        step("refetch0",   32'h0,   0, 0, 0, 8'd0, 32'h0, 32'h0011_0113, 32'h0, 1, 0, 1);
        // write-first read-during-write
        step("wr_first", 32'hC, 0, 0, 1, 8'd3, 32'hFE5F_F06F, 32'hFE5F_F06F, 32'hC, 1, 0, 1);
        step("wr_other", 32'h8, 0, 0, 1, 8'd9, 32'h1234_5678, 32'h0020_8113, 32'h8, 1, 0, 1);
        // faulted fetch, then asynchronous reset in mid-cycle
        step("pre_reset", 32'h6, 0, 0, 0, 8'd0, 32'h0, NOP, 32'h6, 0, 1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        r.name = "async_reset";
        chk_all(r);
        #1;
        rst_n = 1'b1;
        // array contents retained across reset
        step("post_rst0",  32'h0, 0, 0, 0, 8'd0, 32'h0, 32'h0011_0113, 32'h0, 1, 0, 0);
        step("post_rst12", 32'hC, 0, 0, 0, 8'd0, 32'h0, 32'hFE5F_F06F, 32'hC, 1, 0, 0);
        step("post_rst36", 32'h24, 0, 0, 0, 8'd0, 32'h0, 32'h1234_5678, 32'h24, 1, 0, 0);

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
